store_unit: RTL and testbench

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/store_unit.sv | 138 +++++++++++++
 tb/tb_store_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// Sub-word store engine: read-modify-write for sb/sh, direct write for sw.
// Optional macro STORE_MISALIGN_TRAP_EN turns misaligned sh/sw into faulting no-ops.
`timescale 1ns/1ps
module store_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        done,
  output logic        fault,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic        mem_we
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic [2:0]  lat_cnt;
  logic [1:0]  off_q;
  logic        half_q;
  logic [15:0] wdata_q;

  logic        is_sb;
  logic        is_sh;
  logic        is_sw;
  logic        is_nop;
  logic        misaligned;
  logic [31:0] word_addr;
  logic [1:0]  lane;

  function automatic logic [31:0] merge_word(input logic [31:0] rd,
                                             input logic [15:0] wd,
                                             input logic [1:0]  off,
                                             input logic        half);
    logic [31:0] w;
    w = rd;
    if (half) begin
      if (off[1]) w[31:16] = wd;
      else        w[15:0]  = wd;
    end else begin
      case (off)
        2'd0:    w[7:0]   = wd[7:0];
        2'd1:    w[15:8]  = wd[7:0];
        2'd2:    w[23:16] = wd[7:0];
        default: w[31:24] = wd[7:0];
      endcase
    end
    return w;
  endfunction

  assign is_sb     = (req_funct3 == 3'b000);
  assign is_sh     = (req_funct3 == 3'b001);
  assign is_sw     = (req_funct3 == 3'b010);
  assign is_nop    = !(is_sb || is_sh || is_sw);
  assign word_addr = {req_addr[31:2], 2'b00};
  // Halfwords are forced onto an even lane; without the trap this is the alignment fix-up.
  assign lane      = is_sh ? {req_addr[1], 1'b0} : req_addr[1:0];

`ifdef STORE_MISALIGN_TRAP_EN
  assign misaligned = (is_sh && req_addr[0]) || (is_sw && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_cnt   <= '0;
      off_q     <= '0;
      half_q    <= 1'b0;
      wdata_q   <= '0;
    end else begin
      case (state)
        // Accept stage: capture the request and pick the path
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (is_nop || misaligned) begin
              done  <= 1'b1;
              fault <= misaligned;
              state <= DONE;
            end else if (is_sw) begin
              mem_addr  <= word_addr;
              mem_wdata <= req_wdata;
              mem_we    <= 1'b1;
              state     <= WRITE;
            end else begin
              mem_addr <= word_addr;
              off_q    <= lane;
              half_q   <= is_sh;
              wdata_q  <= req_wdata[15:0];
              lat_cnt  <= 3'(READ_LATENCY - 1);
              state    <= READ;
            end
          end
        end
        // Read stage: wait out the memory latency, merge on the final edge
        READ: begin
          if (lat_cnt == 3'd0) begin
            mem_wdata <= merge_word(mem_rdata, wdata_q, off_q, half_q);
            mem_we    <= 1'b1;
            state     <= WRITE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        // Write stage: single write strobe
        WRITE: begin
          mem_we <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        // Retire stage
        DONE: begin
          done      <= 1'b0;
          fault     <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: two instances (READ_LATENCY=1 and 3) with small word memories.
`timescale 1ns/1ps
module tb_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid1 = 1'b0;
  logic        valid3 = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;

  logic        ready1, done1, fault1, mem_we1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;
  logic        ready3, done3, fault3, mem_we3;
  logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];
  logic [31:0] dly3_a = '0;
  logic [31:0] dly3_b = '0;
  int          wr_cnt1 = 0;

  int errors = 0;
  int checks = 0;

  int          wc, wn, dc;
  logic [31:0] wa, wd;
  logic        fl;
  bit          br;

  always #5 clk = ~clk;

  store_unit #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(ready1),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .done(done1), .fault(fault1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1),
    .mem_wdata(mem_wdata1), .mem_we(mem_we1)
  );

  store_unit #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(valid3), .req_ready(ready3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .done(done3), .fault(fault3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3),
    .mem_wdata(mem_wdata3), .mem_we(mem_we3)
  );

  // Latency-1 memory answers combinationally; latency-3 memory sees the address two edges late.
  assign mem_rdata1 = mem1[mem_addr1[11:2]];
  assign mem_rdata3 = mem3[dly3_b[11:2]];

  always @(posedge clk) begin
    dly3_a <= mem_addr3;
    dly3_b <= dly3_a;
    if (mem_we1) begin
      mem1[mem_addr1[11:2]] <= mem_wdata1;
      wr_cnt1 <= wr_cnt1 + 1;
    end
    if (mem_we3) mem3[mem_addr3[11:2]] <= mem_wdata3;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic issue(input bit d3, input logic [31:0] a, input logic [31:0] w, input logic [2:0] f);
    @(negedge clk);
    req_addr = a;
    req_wdata = w;
    req_funct3 = f;
    if (d3) valid3 = 1'b1;
    else    valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    valid3 = 1'b0;
    req_addr = 32'hFFFF_FFFF;
    req_wdata = 32'h5555_5555;
    req_funct3 = 3'b010;
  endtask

  task automatic watch(input bit d3, input int bound);
    wc = -1; wn = 0; dc = -1; wa = '0; wd = '0; fl = 1'b0; br = 1'b0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (d3 ? ready3 : ready1) br = 1'b1;
      if (d3 ? mem_we3 : mem_we1) begin
        if (wc < 0) wc = c;
        wn++;
        wa = d3 ? mem_addr3 : mem_addr1;
        wd = d3 ? mem_wdata3 : mem_wdata1;
      end
      if (d3 ? done3 : done1) begin
        dc = c;
        fl = d3 ? fault3 : fault1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    #1;
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done1); end
    checks++; if (fault1 !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b want=0", fault1); end
    checks++; if (mem_we1 !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", mem_we1); end
    checks++; if (mem_addr1 !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h want=0", mem_addr1); end
    checks++; if (mem_wdata1 !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h want=0", mem_wdata1); end
    checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL reset_ready3 got=%b want=1", ready3); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_sw;
    issue(0, 32'h100, 32'hDEAD_BEEF, 3'b010);
    watch(0, 12);
    checks++; if (wc !== 1) begin errors++; $display("FAIL sw_we_cycle got=%0d want=1", wc); end
    checks++; if (wn !== 1) begin errors++; $display("FAIL sw_we_count got=%0d want=1", wn); end
    checks++; if (wa !== 32'h100) begin errors++; $display("FAIL sw_addr got=%h want=00000100", wa); end
    checks++; if (wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_data got=%h want=deadbeef", wd); end
    checks++; if (dc !== 2) begin errors++; $display("FAIL sw_done_cycle got=%0d want=2", dc); end
    checks++; if (fl !== 1'b0) begin errors++; $display("FAIL sw_fault got=%b want=0", fl); end
    checks++; if (br !== 1'b0) begin errors++; $display("FAIL sw_ready_busy got=%b want=0", br); end
    @(negedge clk);
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL sw_ready_after got=%b want=1", ready1); end
  endtask

  task automatic test_sb;
    mem1[32'h200 >> 2] = 32'h1122_3344;
    issue(0, 32'h202, 32'h7777_77AB, 3'b000);
    watch(0, 12);
    checks++; if (wc !== 2) begin errors++; $display("FAIL sb_we_cycle got=%0d want=2", wc); end
    checks++; if (wn !== 1) begin errors++; $display("FAIL sb_we_count got=%0d want=1", wn); end
    checks++; if (wa !== 32'h200) begin errors++; $display("FAIL sb_addr got=%h want=00000200", wa); end
    checks++; if (wd !== 32'h11AB_3344) begin errors++; $display("FAIL sb_data got=%h want=11ab3344", wd); end
    checks++; if (dc !== 3) begin errors++; $display("FAIL sb_done_cycle got=%0d want=3", dc); end
  endtask

  task automatic test_sh;
    mem1[32'h204 >> 2] = 32'h1122_3344;
    issue(0, 32'h206, 32'h1234_CAFE, 3'b001);
    watch(0, 12);
    checks++; if (wc !== 2) begin errors++; $display("FAIL sh_we_cycle got=%0d want=2", wc); end
    checks++; if (wa !== 32'h204) begin errors++; $display("FAIL sh_addr got=%h want=00000204", wa); end
    checks++; if (wd !== 32'hCAFE_3344) begin errors++; $display("FAIL sh_data got=%h want=cafe3344", wd); end
    checks++; if (dc !== 3) begin errors++; $display("FAIL sh_done_cycle got=%0d want=3", dc); end
    issue(0, 32'h204, 32'h0000_BEEF, 3'b001);
    watch(0, 12);
    checks++; if (wd !== 32'hCAFE_BEEF) begin errors++; $display("FAIL sh_low_data got=%h want=cafebeef", wd); end
    mem3[32'h204 >> 2] = 32'h1122_3344;
    mem3[0] = 32'hFFFF_FFFF;
    issue(1, 32'h206, 32'h0000_CAFE, 3'b001);
    watch(1, 12);
    checks++; if (wc !== 4) begin errors++; $display("FAIL sh_lat3_we_cycle got=%0d want=4", wc); end
    checks++; if (wn !== 1) begin errors++; $display("FAIL sh_lat3_we_count got=%0d want=1", wn); end
    checks++; if (wa !== 32'h204) begin errors++; $display("FAIL sh_lat3_addr got=%h want=00000204", wa); end
    checks++; if (wd !== 32'hCAFE_3344) begin errors++; $display("FAIL sh_lat3_data got=%h want=cafe3344", wd); end
    checks++; if (dc !== 5) begin errors++; $display("FAIL sh_lat3_done_cycle got=%0d want=5", dc); end
    checks++; if (br !== 1'b0) begin errors++; $display("FAIL sh_lat3_ready_busy got=%b want=0", br); end
  endtask

  task automatic test_misalign;
    issue(0, 32'h301, 32'h0A0B_0C0D, 3'b010);
    watch(0, 12);
`ifdef STORE_MISALIGN_TRAP_EN
    checks++; if (wn !== 0) begin errors++; $display("FAIL mis_sw_we_count got=%0d want=0", wn); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL mis_sw_done_cycle got=%0d want=1", dc); end
    checks++; if (fl !== 1'b1) begin errors++; $display("FAIL mis_sw_fault got=%b want=1", fl); end
`else
    checks++; if (wc !== 1) begin errors++; $display("FAIL mis_sw_we_cycle got=%0d want=1", wc); end
    checks++; if (wa !== 32'h300) begin errors++; $display("FAIL mis_sw_addr got=%h want=00000300", wa); end
    checks++; if (wd !== 32'h0A0B_0C0D) begin errors++; $display("FAIL mis_sw_data got=%h want=0a0b0c0d", wd); end
    checks++; if (dc !== 2) begin errors++; $display("FAIL mis_sw_done_cycle got=%0d want=2", dc); end
    checks++; if (fl !== 1'b0) begin errors++; $display("FAIL mis_sw_fault got=%b want=0", fl); end
`endif
    mem1[32'h208 >> 2] = 32'h1122_3344;
    issue(0, 32'h20B, 32'h0000_BEEF, 3'b001);
    watch(0, 12);
`ifdef STORE_MISALIGN_TRAP_EN
    checks++; if (wn !== 0) begin errors++; $display("FAIL mis_sh_we_count got=%0d want=0", wn); end
    checks++; if (fl !== 1'b1) begin errors++; $display("FAIL mis_sh_fault got=%b want=1", fl); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL mis_sh_done_cycle got=%0d want=1", dc); end
`else
    checks++; if (wa !== 32'h208) begin errors++; $display("FAIL mis_sh_addr got=%h want=00000208", wa); end
    checks++; if (wd !== 32'hBEEF_3344) begin errors++; $display("FAIL mis_sh_data got=%h want=beef3344", wd); end
    checks++; if (fl !== 1'b0) begin errors++; $display("FAIL mis_sh_fault got=%b want=0", fl); end
`endif
    issue(0, 32'h20B, 32'h0000_0099, 3'b000);
    watch(0, 12);
`ifdef STORE_MISALIGN_TRAP_EN
    checks++; if (wd !== 32'h9922_3344) begin errors++; $display("FAIL odd_sb_data got=%h want=99223344", wd); end
`else
    checks++; if (wd !== 32'h99EF_3344) begin errors++; $display("FAIL odd_sb_data got=%h want=99ef3344", wd); end
`endif
    checks++; if (fl !== 1'b0) begin errors++; $display("FAIL odd_sb_fault got=%b want=0", fl); end
  endtask

  task automatic test_noop;
    logic [2:0]  ops [2];
    logic [31:0] held_a;
    logic [31:0] held_d;
    ops[0] = 3'b011;
    ops[1] = 3'b111;
    for (int i = 0; i < 2; i++) begin
      held_a = mem_addr1;
      held_d = mem_wdata1;
      issue(0, 32'h400, 32'h1357_9BDF, ops[i]);
      watch(0, 12);
      checks++; if (wn !== 0) begin errors++; $display("FAIL noop_we_count op=%b got=%0d want=0", ops[i], wn); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL noop_done_cycle op=%b got=%0d want=1", ops[i], dc); end
      checks++; if (fl !== 1'b0) begin errors++; $display("FAIL noop_fault op=%b got=%b want=0", ops[i], fl); end
      checks++; if (mem_addr1 !== held_a) begin errors++; $display("FAIL noop_addr_hold got=%h want=%h", mem_addr1, held_a); end
      checks++; if (mem_wdata1 !== held_d) begin errors++; $display("FAIL noop_wdata_hold got=%h want=%h", mem_wdata1, held_d); end
    end
  endtask

  task automatic test_reset_abort;
    int n0;
    mem1[32'h500 >> 2] = 32'h1122_3344;
    n0 = wr_cnt1;
    issue(0, 32'h500, 32'h0000_00AB, 3'b000);
    #2 reset = 1'b0;
    #1;
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b want=1", ready1); end
    checks++; if (mem_we1 !== 1'b0) begin errors++; $display("FAIL abort_we got=%b want=0", mem_we1); end
    checks++; if (mem_addr1 !== 32'h0) begin errors++; $display("FAIL abort_addr got=%h want=0", mem_addr1); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    watch(0, 8);
    checks++; if (wn !== 0) begin errors++; $display("FAIL abort_we_count got=%0d want=0", wn); end
    checks++; if (dc !== -1) begin errors++; $display("FAIL abort_done got=%0d want=-1", dc); end
    checks++; if (wr_cnt1 !== n0) begin errors++; $display("FAIL abort_writes got=%0d want=%0d", wr_cnt1, n0); end
    checks++; if (mem1[32'h500 >> 2] !== 32'h1122_3344) begin errors++; $display("FAIL abort_mem got=%h want=11223344", mem1[32'h500 >> 2]); end
  endtask

  task automatic test_back_to_back;
    int          we_c [2];
    logic [31:0] we_a [2];
    logic [31:0] we_d [2];
    int          dn_c [2];
    logic        rdy  [9];
    int nw;
    int nd;
    nw = 0; nd = 0;
    we_c[0] = -1; we_c[1] = -1; dn_c[0] = -1; dn_c[1] = -1;
    we_a[0] = '0; we_a[1] = '0; we_d[0] = '0; we_d[1] = '0;
    @(negedge clk);
    req_addr = 32'h600; req_wdata = 32'hAAAA_0001; req_funct3 = 3'b010; valid1 = 1'b1;
    @(posedge clk);
    #1 req_addr = 32'h604; req_wdata = 32'hBBBB_0002;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      rdy[c] = ready1;
      if (mem_we1 && nw < 2) begin we_c[nw] = c; we_a[nw] = mem_addr1; we_d[nw] = mem_wdata1; nw++; end
      if (done1 && nd < 2) begin dn_c[nd] = c; nd++; end
      if (c == 3) begin
        @(posedge clk);
        #1 valid1 = 1'b0; req_wdata = 32'hCCCC_0003; req_addr = 32'h608;
      end
    end
    checks++; if (nw !== 2) begin errors++; $display("FAIL b2b_write_count got=%0d want=2", nw); end
    checks++; if (we_c[0] !== 1) begin errors++; $display("FAIL b2b_we0_cycle got=%0d want=1", we_c[0]); end
    checks++; if (we_c[1] !== 4) begin errors++; $display("FAIL b2b_we1_cycle got=%0d want=4", we_c[1]); end
    checks++; if (we_a[0] !== 32'h600) begin errors++; $display("FAIL b2b_addr0 got=%h want=00000600", we_a[0]); end
    checks++; if (we_a[1] !== 32'h604) begin errors++; $display("FAIL b2b_addr1 got=%h want=00000604", we_a[1]); end
    checks++; if (we_d[0] !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_data0 got=%h want=aaaa0001", we_d[0]); end
    checks++; if (we_d[1] !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_data1 got=%h want=bbbb0002", we_d[1]); end
    checks++; if (dn_c[0] !== 2) begin errors++; $display("FAIL b2b_done0_cycle got=%0d want=2", dn_c[0]); end
    checks++; if (dn_c[1] !== 5) begin errors++; $display("FAIL b2b_done1_cycle got=%0d want=5", dn_c[1]); end
    checks++; if (rdy[3] !== 1'b1) begin errors++; $display("FAIL b2b_idle_gap got=%b want=1", rdy[3]); end
    checks++; if (rdy[4] !== 1'b0) begin errors++; $display("FAIL b2b_busy_second got=%b want=0", rdy[4]); end
    checks++; if (rdy[6] !== 1'b1) begin errors++; $display("FAIL b2b_idle_end got=%b want=1", rdy[6]); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 32'hFFFF_FFFF;
      mem3[i] = 32'hFFFF_FFFF;
    end
    test_reset();
    test_sw();
    test_sb();
    test_sh();
    test_misalign();
    test_noop();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
